// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide engine: op codes, FSM states and
// the decode from execute-stage alucontrol codes.
package muldiv_defs;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_MUL    = 2'b01,
    S_DIV    = 2'b10,
    S_FINISH = 2'b11
  } md_state_e;

  localparam logic [7:0] EXE_MULT  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU  = 8'b0001_1011;

  function automatic md_op_e alu2md(input logic [7:0] alucontrol);
    case (alucontrol)
      EXE_MULTU: return MD_MULTU;
      EXE_DIV:   return MD_DIV;
      EXE_DIVU:  return MD_DIVU;
      default:   return MD_MULT;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_signfix.sv
// Two's-complement conditioning: negates hi/lo halves independently, or the
// whole {hi,lo} as one 2*WIDTH value when wide_i is set (sign from neg_lo_i).
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  input  logic             wide_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] w_wide, w_wide_neg;
  logic [WIDTH-1:0]   w_hi_neg, w_lo_neg;

  assign w_wide     = {hi_i, lo_i};
  assign w_wide_neg = -w_wide;
  assign w_hi_neg   = -hi_i;
  assign w_lo_neg   = -lo_i;

  always_comb begin
    hi_o = neg_hi_i ? w_hi_neg : hi_i;
    lo_o = neg_lo_i ? w_lo_neg : lo_i;
    if (wide_i)
      {hi_o, lo_o} = neg_lo_i ? w_wide_neg : w_wide;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the execute stage. Works on
// magnitudes and fixes signs in FINISH; result delivered as {hi,lo}.
module muldiv_unit
  import muldiv_defs::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          r_state, w_next;
  md_op_e             w_op;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_dz_out;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH:0]     r_rem;
  logic [2*WIDTH-1:0] r_result;

  logic               w_signed, w_is_div, w_accept, w_dz_start, w_last, w_fin;
  logic [WIDTH-1:0]   w_abs1, w_abs2, w_fhi, w_flo;
  logic [WIDTH:0]     w_sh, w_diff, w_sum;
  logic               w_ge, w_unused;
  logic [2*WIDTH-1:0] w_prod;

  assign w_op       = md_op_e'(op_i);
  assign w_signed   = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_is_div   = (w_op == MD_DIV) || (w_op == MD_DIVU);
  assign w_accept   = (r_state == S_IDLE) && start_i && !annul_i;
  assign w_dz_start = w_accept && w_is_div && (opdata2_i == '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_in (
    .hi_i(opdata1_i), .lo_i(opdata2_i),
    .neg_hi_i(w_signed & opdata1_i[WIDTH-1]),
    .neg_lo_i(w_signed & opdata2_i[WIDTH-1]),
    .wide_i(1'b0), .hi_o(w_abs1), .lo_o(w_abs2)
  );

  // Restoring divide step: shift next dividend bit (r_a MSB) into remainder.
  assign w_sh   = {r_rem[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_ge   = (w_sh >= {1'b0, r_b});
  assign w_diff = w_sh - {1'b0, r_b};

  // Shift-add multiply: hi accumulates in r_rem, multiplier shifts out of r_a.
  assign w_sum  = {1'b0, r_rem[WIDTH-1:0]} + (r_a[0] ? {1'b0, r_b} : '0);
  assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_unused = r_rem[WIDTH];

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_out (
    .hi_i(r_rem[WIDTH-1:0]), .lo_i(r_a),
    .neg_hi_i(r_neg_r & r_is_div), .neg_lo_i(r_neg_q),
    .wide_i(!r_is_div), .hi_o(w_fhi), .lo_o(w_flo)
  );

  assign w_fin      = (r_state == S_FINISH) && !annul_i;
  assign busy_o     = (r_state == S_MUL) || (r_state == S_DIV);
  assign stall_o    = (start_i && (r_state == S_IDLE) && !annul_i) || busy_o;
  assign ready_o    = w_fin;
  assign result_o   = w_fin ? {w_fhi, w_flo} : r_result;
  assign div_zero_o = w_fin ? r_dz : r_dz_out;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept)
          w_next = w_dz_start ? S_FINISH : (w_is_div ? S_DIV : S_MUL);
      S_MUL:
        if (annul_i)                w_next = S_IDLE;
        else if (FAST_MUL || w_last) w_next = S_FINISH;
      S_DIV:
        if (annul_i)     w_next = S_IDLE;
        else if (w_last) w_next = S_FINISH;
      default:           w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_dz_out <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE:
          if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_b      <= w_abs2;
            r_dz     <= w_dz_start;
            if (w_dz_start) begin
              // Divide-by-zero bypasses the fix-up: {dividend, all-ones}.
              r_rem   <= {1'b0, opdata1_i};
              r_a     <= '1;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_rem   <= '0;
              r_a     <= w_abs1;
              r_neg_q <= w_signed & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              r_neg_r <= w_signed & opdata1_i[WIDTH-1];
            end
          end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (FAST_MUL) begin
            r_rem <= {1'b0, w_prod[2*WIDTH-1:WIDTH]};
            r_a   <= w_prod[WIDTH-1:0];
          end else begin
            r_rem <= {1'b0, w_sum[WIDTH:1]};
            r_a   <= {w_sum[0], r_a[WIDTH-1:1]};
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          r_rem <= w_ge ? w_diff : w_sh;
          r_a   <= {r_a[WIDTH-2:0], w_ge};
        end
        default:
          if (!annul_i) begin
            r_result <= {w_fhi, w_flo};
            r_dz_out <= r_dz;
          end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench: 32-bit fast-mul, 32-bit iterative-mul and 8-bit instances.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]       st, an, rdy, bsy, stl, dzo;
  logic [2:0][1:0]  opv;
  logic [2:0][31:0] a, b;
  logic [2:0][63:0] res;
  int total = 0, bad = 0;
  int cyc, nst;
  logic [63:0] prior;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) u_f (
    .clk(clk), .rst(rst), .start_i(st[0]), .op_i(opv[0]), .opdata1_i(a[0]),
    .opdata2_i(b[0]), .annul_i(an[0]), .busy_o(bsy[0]), .stall_o(stl[0]),
    .ready_o(rdy[0]), .result_o(res[0]), .div_zero_o(dzo[0]));

  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) u_s (
    .clk(clk), .rst(rst), .start_i(st[1]), .op_i(opv[1]), .opdata1_i(a[1]),
    .opdata2_i(b[1]), .annul_i(an[1]), .busy_o(bsy[1]), .stall_o(stl[1]),
    .ready_o(rdy[1]), .result_o(res[1]), .div_zero_o(dzo[1]));

  muldiv_unit #(.WIDTH(8), .FAST_MUL(1'b0)) u_e (
    .clk(clk), .rst(rst), .start_i(st[2]), .op_i(opv[2]), .opdata1_i(a[2][7:0]),
    .opdata2_i(b[2][7:0]), .annul_i(an[2]), .busy_o(bsy[2]), .stall_o(stl[2]),
    .ready_o(rdy[2]), .result_o(res[2][15:0]), .div_zero_o(dzo[2]));
  assign res[2][63:16] = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts an op on instance d and returns in the cycle ready_o is seen
  // (bounded); ocyc = cycles after start, onst = stall_o-high cycles before it.
  task automatic run(input int d, input bit now, input logic [1:0] op,
                     input logic [31:0] x, input logic [31:0] y,
                     output int ocyc, output int onst);
    if (!now) @(negedge clk);
    st[d] = 1'b1; opv[d] = op; a[d] = x; b[d] = y;
    #1;
    onst = int'(stl[d]);
    ocyc = 0;
    while (!rdy[d] && ocyc < 100) begin
      @(negedge clk);
      if (!rdy[d] && stl[d]) onst++;
      st[d] = 1'b0;
      ocyc++;
    end
  endtask

  initial begin
    rst = 1'b1; st = '0; an = '0; opv = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(rdy[0]), 64'd0);
    chk("rst_busy", 64'(bsy[0]), 64'd0);
    chk("rst_result", res[0], 64'd0);
    chk("rst_dz", 64'(dzo[0]), 64'd0);
    chk("rst_result8", res[2], 64'd0);
    rst = 1'b0;

    // signed divide, negative divisor
    run(0, 0, OP_DIV, 32'd7, 32'hFFFF_FFFE, cyc, nst);
    chk("div_cyc", 64'(cyc), 64'd33);
    chk("div_stall", 64'(nst), 64'd33);
    chk("div_res", res[0], 64'h0000_0001_FFFF_FFFD);
    chk("div_dz", 64'(dzo[0]), 64'd0);

    run(0, 0, OP_DIVU, 32'hFFFF_FFFF, 32'h10, cyc, nst);
    chk("divu_res", res[0], 64'h0000_000F_0FFF_FFFF);
    run(0, 0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, nst);
    chk("div_ovf_res", res[0], 64'h0000_0000_8000_0000);

    // divide by zero, then a following op clears the flag
    run(0, 0, OP_DIV, 32'h1234, 32'h0, cyc, nst);
    chk("dz_cyc", 64'(cyc), 64'd1);
    chk("dz_flag", 64'(dzo[0]), 64'd1);
    chk("dz_res", res[0], 64'h0000_1234_FFFF_FFFF);
    run(0, 0, OP_MULTU, 32'd2, 32'd3, cyc, nst);
    chk("after_dz_flag", 64'(dzo[0]), 64'd0);
    chk("after_dz_res", res[0], 64'd6);

    // multiply, fast and iterative
    run(0, 0, OP_MULT, 32'hFFFF_FFFE, 32'd3, cyc, nst);
    chk("mult_f_cyc", 64'(cyc), 64'd2);
    chk("mult_f_res", res[0], 64'hFFFF_FFFF_FFFF_FFFA);
    run(0, 0, OP_MULTU, 32'hFFFF_FFFE, 32'd3, cyc, nst);
    chk("multu_f_res", res[0], 64'h0000_0002_FFFF_FFFA);
    run(1, 0, OP_MULT, 32'hFFFF_FFFE, 32'd3, cyc, nst);
    chk("mult_s_cyc", 64'(cyc), 64'd33);
    chk("mult_s_res", res[1], 64'hFFFF_FFFF_FFFF_FFFA);
    run(1, 0, OP_MULTU, 32'hFFFF_FFFE, 32'd3, cyc, nst);
    chk("multu_s_res", res[1], 64'h0000_0002_FFFF_FFFA);

    // annul at cycle 10 of a divide; then DIVU 100/7 the next cycle
    prior = 64'h0000_0002_FFFF_FFFA;
    @(negedge clk);
    st[0] = 1'b1; opv[0] = OP_DIV; a[0] = 32'd1000; b[0] = 32'd3;
    repeat (10) begin @(negedge clk); st[0] = 1'b0; end
    chk("annul_busy_before", 64'(bsy[0]), 64'd1);
    an[0] = 1'b1;
    #1;
    chk("annul_ready", 64'(rdy[0]), 64'd0);
    @(negedge clk);
    an[0] = 1'b0;
    chk("annul_busy_after", 64'(bsy[0]), 64'd0);
    chk("annul_keep_res", res[0], prior);
    run(0, 1, OP_DIVU, 32'd100, 32'd7, cyc, nst);
    chk("post_annul_cyc", 64'(cyc), 64'd33);
    chk("post_annul_res", res[0], 64'h0000_0002_0000_000E);

    // annul and start together in IDLE: annul wins
    @(negedge clk);
    st[0] = 1'b1; an[0] = 1'b1; opv[0] = OP_DIV; a[0] = 32'd5; b[0] = 32'd1;
    #1;
    chk("annul_start_stall", 64'(stl[0]), 64'd0);
    @(negedge clk);
    st[0] = 1'b0; an[0] = 1'b0;
    chk("annul_start_busy", 64'(bsy[0]), 64'd0);

    // 8-bit iterative instance
    run(2, 0, OP_DIV, 32'h9C, 32'h07, cyc, nst);
    chk("w8_div_cyc", 64'(cyc), 64'd9);
    chk("w8_div_res", res[2], 64'hFEF2);
    run(2, 0, OP_MULTU, 32'hFF, 32'hFF, cyc, nst);
    chk("w8_multu_cyc", 64'(cyc), 64'd9);
    chk("w8_multu_res", res[2], 64'hFE01);

    // reset mid-operation
    @(negedge clk);
    st[2] = 1'b1; opv[2] = OP_DIV; a[2] = 32'h50; b[2] = 32'h03;
    @(negedge clk);
    st[2] = 1'b0;
    @(negedge clk);
    chk("w8_midop_busy", 64'(bsy[2]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("w8_rst_busy", 64'(bsy[2]), 64'd0);
    chk("w8_rst_ready", 64'(rdy[2]), 64'd0);
    chk("w8_rst_res", res[2], 64'd0);
    chk("w8_rst_dz", 64'(dzo[2]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
